// File: rtl/pipeline_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_controller : IF-stage control (init, stall, jump flush, halt)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipeline_controller #(
  parameter int LOAD_STALL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode_if,
  input  logic [2:0] operand_if,
  input  logic       ext_stall,
  input  logic       resume,
  output logic       init_regs,
  output logic [2:0] init_addr,
  output logic       halt_if,
  output logic       flush_if,
  output logic       pc_load,
  output logic [2:0] pc_target,
  output logic       halted
);

  localparam logic [2:0] c_st_init      = 3'd0;
  localparam logic [2:0] c_st_run       = 3'd1;
  localparam logic [2:0] c_st_load_wait = 3'd2;
  localparam logic [2:0] c_st_flush     = 3'd3;
  localparam logic [2:0] c_st_halted    = 3'd4;

  localparam logic [2:0] c_op_load = 3'b101;
  localparam logic [2:0] c_op_jump = 3'b110;
  localparam logic [2:0] c_op_halt = 3'b111;

  localparam int         c_stall_clamped = (LOAD_STALL < 1) ? 1 :
                                           (LOAD_STALL > 7) ? 7 : LOAD_STALL;
  localparam logic [2:0] c_load_stall    = 3'(c_stall_clamped);

  logic [2:0] r_state;
  logic [2:0] r_init_cnt;
  logic [2:0] r_stall_cnt;

  logic [2:0] w_state;
  logic [2:0] w_init_cnt;
  logic [2:0] w_state_nxt;
  logic [2:0] w_init_nxt;
  logic [2:0] w_stall_nxt;

  // Reset overrides the registered view so outputs never expose pre-reset state.
  assign w_state    = rst ? c_st_init : r_state;
  assign w_init_cnt = rst ? 3'd0      : r_init_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_stall_nxt = r_stall_cnt;
    case (r_state)
      c_st_init: begin
        if (r_init_cnt == 3'd7) begin
          w_state_nxt = c_st_run;
          w_init_nxt  = 3'd0;
        end else begin
          w_init_nxt  = r_init_cnt + 3'd1;
        end
      end
      c_st_run: begin
        if (!ext_stall) begin
          case (opcode_if)
            c_op_halt: w_state_nxt = c_st_halted;
            c_op_jump: w_state_nxt = c_st_flush;
            c_op_load: begin
              w_state_nxt = c_st_load_wait;
              w_stall_nxt = c_load_stall;
            end
            default:   w_state_nxt = c_st_run;
          endcase
        end
      end
      c_st_load_wait: begin
        if (!ext_stall) begin
          if (r_stall_cnt <= 3'd1) begin
            w_state_nxt = c_st_run;
            w_stall_nxt = 3'd0;
          end else begin
            w_stall_nxt = r_stall_cnt - 3'd1;
          end
        end
      end
      c_st_flush:  w_state_nxt = c_st_run;
      c_st_halted: if (resume) w_state_nxt = c_st_run;
      default: begin
        w_state_nxt = c_st_init;
        w_init_nxt  = 3'd0;
        w_stall_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_init;
      r_init_cnt  <= 3'd0;
      r_stall_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  assign pc_target = operand_if;

  always_comb begin
    init_regs = 1'b0;
    init_addr = 3'd0;
    halt_if   = 1'b0;
    flush_if  = 1'b0;
    pc_load   = 1'b0;
    halted    = 1'b0;
    case (w_state)
      c_st_init: begin
        init_regs = 1'b1;
        init_addr = w_init_cnt;
      end
      c_st_run: begin
        if (ext_stall) begin
          halt_if = 1'b1;
        end else if (opcode_if == c_op_halt) begin
          halt_if = 1'b1;
        end else if (opcode_if == c_op_jump) begin
          pc_load = 1'b1;
        end
      end
      c_st_load_wait: halt_if = 1'b1;
      c_st_flush: begin
        flush_if = 1'b1;
        halt_if  = ext_stall;
      end
      c_st_halted: begin
        halted  = 1'b1;
        halt_if = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_controller : scoreboard bench with behavioural phase model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pipeline_controller;

  localparam int LOAD_STALL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode_if = 3'd0;
  logic [2:0] operand_if = 3'd0;
  logic       ext_stall = 1'b0;
  logic       resume = 1'b0;
  logic       init_regs;
  logic [2:0] init_addr;
  logic       halt_if;
  logic       flush_if;
  logic       pc_load;
  logic [2:0] pc_target;
  logic       halted;

  pipeline_controller #(.LOAD_STALL(LOAD_STALL)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode_if (opcode_if),
    .operand_if(operand_if),
    .ext_stall (ext_stall),
    .resume    (resume),
    .init_regs (init_regs),
    .init_addr (init_addr),
    .halt_if   (halt_if),
    .flush_if  (flush_if),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir;
    logic [2:0] ia;
    logic       hi;
    logic       fi;
    logic       pl;
    logic [2:0] pt;
    logic       h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Behavioural model: progress through init, pending wait cycles, pending flush, halt flag.
  int init_done_cycles = 0;
  int wait_left        = 0;
  bit flush_pending    = 0;
  bit is_halted        = 0;

  task automatic step(input bit r, input logic [2:0] op, input logic [2:0] opd,
                      input bit st, input bit res);
    exp_t e;
    rst = r; opcode_if = op; operand_if = opd; ext_stall = st; resume = res;
    e = '0;
    e.pt = opd;
    if (r || init_done_cycles < 8) begin
      e.ir = 1'b1;
      e.ia = r ? 3'd0 : 3'(init_done_cycles);
    end else if (is_halted) begin
      e.h = 1'b1; e.hi = 1'b1;
    end else if (wait_left > 0) begin
      e.hi = 1'b1;
    end else if (flush_pending) begin
      e.fi = 1'b1; e.hi = st;
    end else begin
      e.hi = st || (op == 3'd7);
      e.pl = !st && (op == 3'd6);
    end
    exp_q.push_back(e);
    if (r) begin
      init_done_cycles = 0; wait_left = 0; flush_pending = 0; is_halted = 0;
    end else if (init_done_cycles < 8) begin
      init_done_cycles++;
    end else if (is_halted) begin
      if (res) is_halted = 0;
    end else if (wait_left > 0) begin
      if (!st) wait_left--;
    end else if (flush_pending) begin
      flush_pending = 0;
    end else if (!st) begin
      if (op == 3'd7) is_halted = 1;
      else if (op == 3'd6) flush_pending = 1;
      else if (op == 3'd5) wait_left = LOAD_STALL;
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {init_regs, init_addr, halt_if, flush_if, pc_load, pc_target, halted};
        if (!e.ir) a.ia = 3'd0;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got ir=%b ia=%0d hi=%b fi=%b pl=%b pt=%0d h=%b expected ir=%b ia=%0d hi=%b fi=%b pl=%b pt=%0d h=%b",
                   cyc, a.ir, a.ia, a.hi, a.fi, a.pl, a.pt, a.h,
                   e.ir, e.ia, e.hi, e.fi, e.pl, e.pt, e.h);
        end
        cyc++;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 3'(i), 0, 0);
  endtask

  initial begin : stimulus
    @(posedge clk); #1;
    // Reset then idle through the full init sequence into RUN.
    step(1, 3'd0, 3'd0, 0, 0);
    idle(10);
    // Jump with operand 101, then flush, then run.
    step(0, 3'd6, 3'd5, 0, 0);
    idle(3);
    // Load with a one-cycle stall inside the wait.
    step(0, 3'd5, 3'd2, 0, 0);
    step(0, 3'd0, 3'd0, 1, 0);
    idle(4);
    // Resume in RUN is ignored; halt holds until resume.
    step(0, 3'd1, 3'd0, 0, 1);
    step(0, 3'd7, 3'd0, 0, 0);
    step(0, 3'd6, 3'd3, 1, 0);
    step(0, 3'd6, 3'd3, 0, 0);
    step(0, 3'd0, 3'd0, 0, 1);
    idle(2);
    // Stalled jump is held, taken once the stall drops.
    step(0, 3'd6, 3'd4, 1, 0);
    step(0, 3'd6, 3'd4, 1, 0);
    step(0, 3'd6, 3'd4, 0, 0);
    step(0, 3'd0, 3'd0, 1, 0);
    idle(2);
    // Reset during load wait (counter at 1), then during init at addr 5.
    step(0, 3'd5, 3'd0, 0, 0);
    step(0, 3'd0, 3'd0, 0, 0);
    step(1, 3'd0, 3'd0, 0, 0);
    idle(5);
    step(1, 3'd0, 3'd0, 0, 0);
    idle(10);
    // Random traffic; ordinary opcodes 000-100 included.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));
    end
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
